// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for signed or unsigned operands. It produces a 2*WIDTH-bit product with a one-cycle out_en strobe.
// Optional build macro MULT_EARLY_TERM_EN: stop as soon as the remaining multiplier bits are zero.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_en,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             out_en,
  output logic [WIDTH-1:0] p_hi,
  output logic [WIDTH-1:0] p_lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     p_hi_q, p_hi_d;
  logic [WIDTH-1:0]     p_lo_q, p_lo_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   acc_nxt, prod;
  logic                 start, last_iter;

  // Magnitudes are taken as unsigned, so the most negative value maps cleanly to 2^(WIDTH-1).
  assign a_mag   = (sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag   = (sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign start   = in_en && (state_q != RUN);
  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod    = neg_q ? (~acc_nxt + (2*WIDTH)'(1)) : acc_nxt;

`ifdef MULT_EARLY_TERM_EN
  assign last_iter = (cnt_q == LAST_CNT) || (mplier_q[WIDTH-1:1] == '0);
`else
  assign last_iter = (cnt_q == LAST_CNT);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_en) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = in_en ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      mplier_d = b_mag;
      acc_d    = '0;
      cnt_d    = '0;
      neg_d    = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (state_q == RUN) begin
      acc_d    = acc_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last_iter) begin
        p_hi_d = prod[2*WIDTH-1:WIDTH];
        p_lo_d = prod[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    busy   = (state_q == RUN);
    out_en = (state_q == DONE);
    p_hi   = p_hi_q;
    p_lo   = p_lo_q;
  end

endmodule
